rpn_exec: RTL and testbench

- Token-driven RPN execution unit that sits directly in front of the 8-bit operand stack; it is the stack's only client.
- Number tokens are pushed straight onto the stack.
- Operator tokens pop their operands, compute an 8-bit result and push that result back.
- Underflow, overflow and result events are reported to the display/control logic.

---
 rtl/rpn_pkg.sv | 31 +++
 rtl/rpn_alu.sv | 29 ++
 rtl/rpn_exec.sv | 173 +++++++++++++++++
 tb/tb_rpn_exec.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared constants, error codes and FSM states for the RPN execution unit.
package rpn_pkg;

    localparam int DW = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NEG  = 3'd6;
    localparam logic [2:0] OP_PEEK = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_NUM,
        S_POP_B,
        S_SETTLE,
        S_POP_A,
        S_EXEC,
        S_PUSH_RES,
        S_RESTORE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Purely combinational 8-bit operator datapath; b is the top-of-stack operand.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res
);

    logic [2*DW-1:0] prod;

    assign prod = a * b;

    always_comb begin
        res = a;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = prod[DW-1:0];
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NEG:  res = '0 - a;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/rpn_exec.sv
// Token-driven RPN executor and sole client of the operand stack.
// Pushes hold until acked or ACK_TIMEOUT expires; tokens are taken only in IDLE/ERROR.
module rpn_exec
    import rpn_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          tok_valid,
    input  logic          tok_is_op,
    input  logic [DW-1:0] tok_dat,
    output logic          tok_ready,
    output logic          push,
    output logic [DW-1:0] push_dat,
    input  logic          push_ack,
    input  logic          pop,
    input  logic [DW-1:0] pop_dat,
    output logic          pop_ack,
    output logic          res_valid,
    output logic [DW-1:0] res_dat,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [DW-1:0] a_q, b_q, num_q, result_q, res_q, res_nx, alu_res;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt;
    logic [1:0]    err_code_q, err_code_nx;
    logic          ack_expired;

    rpn_alu u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (alu_res)
    );

    // Only meaningful while a push is pending without ack.
    assign ack_expired = (cnt == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        state_nx    = state;
        tok_ready   = 1'b0;
        push        = 1'b0;
        push_dat    = '0;
        pop_ack     = 1'b0;
        res_valid   = 1'b0;
        res_nx      = res_q;
        err_code_nx = err_code_q;
        case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    if (!tok_is_op) begin
                        state_nx = S_PUSH_NUM;
                    end else if (tok_dat[2:0] == OP_NEG) begin
                        state_nx = S_POP_A;
                    end else if (tok_dat[2:0] == OP_PEEK) begin
                        if (pop) begin
                            res_valid = 1'b1;
                            res_nx    = pop_dat;
                        end else begin
                            state_nx    = S_ERROR;
                            err_code_nx = ERR_UNDER;
                        end
                    end else begin
                        state_nx = S_POP_B;
                    end
                end
            end
            S_PUSH_NUM: begin
                push     = 1'b1;
                push_dat = num_q;
                if (push_ack) begin
                    state_nx = S_IDLE;
                end else if (ack_expired) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_OVER;
                end
            end
            S_POP_B: begin
                if (pop) begin
                    pop_ack  = 1'b1;
                    state_nx = S_SETTLE;
                end else begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_UNDER;
                end
            end
            S_SETTLE: state_nx = S_POP_A;
            S_POP_A: begin
                if (pop) begin
                    pop_ack  = 1'b1;
                    state_nx = S_EXEC;
                end else if (op_q == OP_NEG) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_UNDER;
                end else begin
                    state_nx = S_RESTORE;
                end
            end
            S_EXEC: state_nx = S_PUSH_RES;
            S_PUSH_RES: begin
                push     = 1'b1;
                push_dat = result_q;
                if (push_ack) begin
                    res_valid = 1'b1;
                    res_nx    = result_q;
                    state_nx  = S_IDLE;
                end else if (ack_expired) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_OVER;
                end
            end
            // Put b back so a failed binary op leaves the stack as it was.
            S_RESTORE: begin
                push     = 1'b1;
                push_dat = b_q;
                if (push_ack) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_UNDER;
                end else if (ack_expired) begin
                    state_nx    = S_ERROR;
                    err_code_nx = ERR_OVER;
                end
            end
            S_ERROR: begin
                tok_ready = 1'b1;
                if (clr) begin
                    state_nx    = S_IDLE;
                    err_code_nx = ERR_NONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign res_dat  = res_nx;
    assign err      = (state == S_ERROR);
    assign err_code = err_code_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            num_q      <= '0;
            result_q   <= '0;
            res_q      <= '0;
            op_q       <= '0;
            cnt        <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_nx;
            res_q      <= res_nx;
            err_code_q <= err_code_nx;
            if (state == S_IDLE && tok_valid) begin
                op_q <= tok_dat[2:0];
                if (!tok_is_op) num_q <= tok_dat;
            end
            if (pop_ack && state == S_POP_B) b_q <= pop_dat;
            if (pop_ack && state == S_POP_A) a_q <= pop_dat;
            if (state == S_EXEC) result_q <= alu_res;
            cnt <= (push && !push_ack) ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_rpn_exec.sv
// Scoreboarded bench for rpn_exec against a behavioural operand stack.
`timescale 1ns/1ps
module tb_rpn_exec;

    logic       clk = 1'b0;
    logic       reset, clr, tok_valid, tok_is_op;
    logic [7:0] tok_dat;
    logic       tok_ready, push, push_ack, pop, pop_ack, res_valid, err;
    logic [7:0] push_dat, pop_dat, res_dat;
    logic [1:0] err_code;

    rpn_exec #(.ACK_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .tok_valid (tok_valid),
        .tok_is_op (tok_is_op),
        .tok_dat   (tok_dat),
        .tok_ready (tok_ready),
        .push      (push),
        .push_dat  (push_dat),
        .push_ack  (push_ack),
        .pop       (pop),
        .pop_dat   (pop_dat),
        .pop_ack   (pop_ack),
        .res_valid (res_valid),
        .res_dat   (res_dat),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural stack, 16 deep
    logic [7:0] mem [0:15];
    int  depth = 0;
    bit  force_full = 1'b0;
    bit  stk_flush = 1'b0;

    assign push_ack = push && !force_full && (depth < 16);
    assign pop      = (depth > 0);
    assign pop_dat  = (depth > 0) ? mem[4'(depth - 1)] : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stk_flush) depth <= 0;
        else if (push && push_ack) begin
            mem[depth[3:0]] <= push_dat;
            depth <= depth + 1;
        end else if (pop_ack && depth > 0) depth <= depth - 1;
    end

    // Scoreboard
    logic [7:0] exp_push[$];
    logic [7:0] exp_res[$];
    int pa_cyc[$];
    int push_hi = 0, push_cnt = 0, pa_cnt = 0, res_cnt = 0, res_cyc = 0;

    always @(negedge clk) begin
        if (push) push_hi++;
        if (pop_ack) begin
            pa_cnt++;
            pa_cyc.push_back(cyc);
        end
        if (push && push_ack) begin
            push_cnt++;
            if (exp_push.size() == 0) chk("push_sb_empty", 32'(exp_push.size()), 32'd1);
            else chk("push_dat", 32'(push_dat), 32'(exp_push.pop_front()));
        end
        if (res_valid) begin
            res_cnt++;
            res_cyc = cyc;
            if (exp_res.size() == 0) chk("res_sb_empty", 32'(exp_res.size()), 32'd1);
            else chk("res_dat", 32'(res_dat), 32'(exp_res.pop_front()));
        end
    end

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return p[7:0];
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return 8'h00 - a;
            default: return a;
        endcase
    endfunction

    // All stimulus tasks run in the phase #1 after a rising edge.
    task automatic wait_ready();
        int n = 0;
        while (!tok_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tok_ready) chk("ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic send_tok(input logic op, input logic [7:0] d, output int t);
        wait_ready();
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_dat   = d;
        t = cyc;
        @(posedge clk); #1;
        tok_valid = 1'b0;
    endtask

    task automatic push_num(input logic [7:0] d);
        int t;
        exp_push.push_back(d);
        send_tok(1'b0, d, t);
        wait_ready();
    endtask

    task automatic binop(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int t);
        push_num(a);
        push_num(b);
        exp_push.push_back(ref_alu(op, a, b));
        exp_res.push_back(ref_alu(op, a, b));
        send_tok(1'b1, {5'b0, op}, t);
        wait_ready();
    endtask

    task automatic flush();
        stk_flush = 1'b1;
        @(posedge clk); #1;
        stk_flush = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        int t, pa0, ph0, pc0, rc0, pq0;
        reset = 1'b1; clr = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_dat = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_tok_ready", 32'(tok_ready), 32'd1);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_pop_ack", 32'(pop_ack), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_dat", 32'(res_dat), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);

        // 3 5 ADD with latency checks
        pq0 = pa_cyc.size();
        binop(8'd3, 8'd5, 3'd0, t);
        chk("add_res_cyc", 32'(res_cyc), 32'(t + 5));
        chk("add_ready_cyc", 32'(cyc), 32'(t + 6));
        chk("add_npop", 32'(pa_cyc.size() - pq0), 32'd2);
        if (pa_cyc.size() - pq0 == 2) begin
            chk("add_pop1_cyc", 32'(pa_cyc[pq0]), 32'(t + 1));
            chk("add_pop2_cyc", 32'(pa_cyc[pq0 + 1]), 32'(t + 3));
        end
        chk("add_depth", 32'(depth), 32'd1);
        chk("add_top", 32'(pop_dat), 32'd8);

        flush();
        binop(8'd2, 8'd7, 3'd1, t);
        chk("sub_res_dat", 32'(res_dat), 32'hFB);
        chk("sub_depth", 32'(depth), 32'd1);
        flush();
        binop(8'h20, 8'h10, 3'd2, t);
        chk("mul_res_dat", 32'(res_dat), 32'h00);
        flush();
        binop(8'hC3, 8'h5A, 3'd5, t);
        chk("xor_top", 32'(pop_dat), 32'h99);

        // Underflow on empty stack
        flush();
        pa0 = pa_cnt;
        send_tok(1'b1, 8'd0, t);
        wait_ready();
        chk("uf0_err", 32'(err), 32'd1);
        chk("uf0_code", 32'(err_code), 32'd1);
        chk("uf0_npop", 32'(pa_cnt - pa0), 32'd0);
        pulse_clr();
        chk("uf0_clr_err", 32'(err), 32'd0);

        // Underflow with one entry: b restored
        flush();
        push_num(8'd9);
        pa0 = pa_cnt;
        exp_push.push_back(8'd9);
        send_tok(1'b1, 8'd0, t);
        wait_ready();
        chk("uf1_npop", 32'(pa_cnt - pa0), 32'd1);
        chk("uf1_code", 32'(err_code), 32'd1);
        chk("uf1_depth", 32'(depth), 32'd1);
        chk("uf1_top", 32'(pop_dat), 32'd9);
        pulse_clr();
        chk("uf1_clr_ready", 32'(tok_ready), 32'd1);
        chk("uf1_clr_err", 32'(err), 32'd0);
        chk("uf1_clr_code", 32'(err_code), 32'd0);

        // Overflow: push never acked
        flush();
        force_full = 1'b1;
        ph0 = push_hi;
        send_tok(1'b0, 8'h55, t);
        wait_ready();
        chk("ovf_push_cycles", 32'(push_hi - ph0), 32'd8);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_code", 32'(err_code), 32'd2);
        force_full = 1'b0;
        ph0 = push_hi; pa0 = pa_cnt;
        send_tok(1'b0, 8'h11, t);
        send_tok(1'b1, 8'd0, t);
        repeat (4) @(posedge clk);
        #1;
        chk("ovf_ign_push", 32'(push_hi - ph0), 32'd0);
        chk("ovf_ign_pop", 32'(pa_cnt - pa0), 32'd0);
        chk("ovf_ign_code", 32'(err_code), 32'd2);
        pulse_clr();
        chk("ovf_clr_err", 32'(err), 32'd0);

        // NEG then PEEK
        flush();
        push_num(8'd4);
        exp_push.push_back(ref_alu(3'd6, 8'd4, 8'd0));
        exp_res.push_back(ref_alu(3'd6, 8'd4, 8'd0));
        send_tok(1'b1, 8'd6, t);
        wait_ready();
        chk("neg_res_dat", 32'(res_dat), 32'hFC);
        pa0 = pa_cnt; pc0 = push_cnt; rc0 = res_cnt;
        exp_res.push_back(8'hFC);
        send_tok(1'b1, 8'd7, t);
        wait_ready();
        chk("peek_nres", 32'(res_cnt - rc0), 32'd1);
        chk("peek_npop", 32'(pa_cnt - pa0), 32'd0);
        chk("peek_npush", 32'(push_cnt - pc0), 32'd0);
        chk("peek_held", 32'(res_dat), 32'hFC);
        chk("peek_depth", 32'(depth), 32'd1);

        // Reset during SETTLE
        flush();
        push_num(8'd1);
        push_num(8'd2);
        send_tok(1'b1, 8'd0, t);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_push", 32'(push), 32'd0);
        chk("mid_rst_pop_ack", 32'(pop_ack), 32'd0);
        chk("mid_rst_ready", 32'(tok_ready), 32'd1);
        chk("mid_rst_err", 32'(err), 32'd0);
        ph0 = push_hi;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_quiet", 32'(push_hi - ph0), 32'd0);
        chk("mid_rst_depth", 32'(depth), 32'd1);

        chk("sb_push_left", 32'(exp_push.size()), 32'd0);
        chk("sb_res_left", 32'(exp_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
